// File: rtl/muldiv_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit: op encoding (funct3),
// FSM states and small op-decode helpers.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MUL_OP_MUL    = 3'd0,
    MUL_OP_MULH   = 3'd1,
    MUL_OP_MULHSU = 3'd2,
    MUL_OP_MULHU  = 3'd3,
    MUL_OP_DIV    = 3'd4,
    MUL_OP_DIVU   = 3'd5,
    MUL_OP_REM    = 3'd6,
    MUL_OP_REMU   = 3'd7
  } mul_ops_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } muldiv_state_t;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic is_div(input mul_ops_t op);
    logic [2:0] v;
    v = op;
    return v[2];
  endfunction

  // REM/REMU return the remainder rather than the quotient
  function automatic logic is_rem(input mul_ops_t op);
    logic [2:0] v;
    v = op;
    return v[2] & v[1];
  endfunction

  // rs1 is signed for everything except the fully unsigned ops
  function automatic logic a_signed(input mul_ops_t op);
    return !(op == MUL_OP_MULHU || op == MUL_OP_DIVU || op == MUL_OP_REMU);
  endfunction

  // rs2 is signed only for MUL, MULH, DIV and REM
  function automatic logic b_signed(input mul_ops_t op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULH) ||
           (op == MUL_OP_DIV) || (op == MUL_OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference if it
// stays non-negative and shift the matching quotient bit in.
module muldiv_unit_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);

  // One extra bit above the shifted remainder makes the borrow an exact sign
  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] trial;

  // Trial subtract and restore
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    trial   = shifted - {2'b00, divisor};
    if (!trial[XLEN+1]) begin
      rem_next = trial[XLEN:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute unit: iterative restoring divider and a single-cycle or
// shift-add multiplier, sequenced by an IDLE/BUSY/DONE FSM that stalls the
// front of the pipeline while an op is in flight.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            stall_req_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  muldiv_state_t     state;
  mul_ops_t          op_q;
  logic              neg_q;
  logic              neg_r;
  logic [CW-1:0]     count;
  logic [XLEN:0]     rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   dvsr_q;
  logic [2*XLEN-1:0] prod_q;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_w(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Operand decode, valid only while IDLE samples a new op
  mul_ops_t               op_in;
  logic                   a_sgn, b_sgn;
  logic [XLEN-1:0]        a_mag, b_mag;
  logic                   div_zero, div_ovf;
  logic signed [XLEN:0]   a_ext, b_ext;
  logic signed [2*XLEN-1:0] prod_full;
  logic [XLEN-1:0]        fast_res;

  assign op_in    = mul_ops_t'(op_i);
  assign a_sgn    = a_signed(op_in) & a_i[XLEN-1];
  assign b_sgn    = b_signed(op_in) & b_i[XLEN-1];
  assign a_mag    = cond_neg(a_i, a_sgn);
  assign b_mag    = cond_neg(b_i, b_sgn);
  assign div_zero = (b_i == '0);
  assign div_ovf  = b_signed(op_in) && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);

  // 33x33 signed multiply covers all three signedness combinations
  assign a_ext     = $signed({a_signed(op_in) & a_i[XLEN-1], a_i});
  assign b_ext     = $signed({b_signed(op_in) & b_i[XLEN-1], b_i});
  assign prod_full = (2*XLEN)'(a_ext * b_ext);
  assign fast_res  = (op_in == MUL_OP_MUL) ? prod_full[XLEN-1:0] : prod_full[2*XLEN-1:XLEN];

  // Per-cycle iteration datapath
  logic [XLEN:0]     rem_nx;
  logic [XLEN-1:0]   quo_nx;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_nx;

  muldiv_unit_div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, dvsr_q} : '0);
  assign prod_nx = {mul_sum, prod_q[XLEN-1:1]};

  // Sign fixup and result select on the final iteration
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   iter_res;

  always_comb begin
    prod_fix = cond_neg_w(prod_nx, neg_q);
    iter_res = '0;
    if (is_div(op_q)) begin
      iter_res = is_rem(op_q) ? cond_neg(rem_nx[XLEN-1:0], neg_r) : cond_neg(quo_nx, neg_q);
    end else if (op_q == MUL_OP_MUL) begin
      iter_res = prod_fix[XLEN-1:0];
    end else begin
      iter_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  assign stall_req_o = start_i & (state != MD_DONE) & ~flush_i & ~rst_i;

  // Control FSM with operand capture, iteration and registered result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= MD_IDLE;
      op_q     <= MUL_OP_MUL;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      count    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      prod_q   <= '0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else if (flush_i) begin
      state  <= MD_IDLE;
      done_o <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start_i) begin
            op_q  <= op_in;
            neg_q <= a_sgn ^ b_sgn;
            neg_r <= a_sgn;
            if (is_div(op_in)) begin
              if (div_zero) begin
                result_o <= is_rem(op_in) ? a_i : '1;
                done_o   <= 1'b1;
                state    <= MD_DONE;
              end else if (div_ovf) begin
                result_o <= is_rem(op_in) ? '0 : a_i;
                done_o   <= 1'b1;
                state    <= MD_DONE;
              end else begin
                rem_q  <= '0;
                quo_q  <= a_mag;
                dvsr_q <= b_mag;
                count  <= CW'(XLEN-1);
                state  <= MD_BUSY;
              end
            end else if (FAST_MUL) begin
              result_o <= fast_res;
              done_o   <= 1'b1;
              state    <= MD_DONE;
            end else begin
              prod_q <= {{XLEN{1'b0}}, a_mag};
              dvsr_q <= b_mag;
              count  <= CW'(XLEN-1);
              state  <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          rem_q  <= rem_nx;
          quo_q  <= quo_nx;
          prod_q <= prod_nx;
          count  <= count - 1'b1;
          if (count == '0) begin
            result_o <= iter_res;
            done_o   <= 1'b1;
            state    <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (!hold_i) begin
            done_o <= 1'b0;
            state  <= MD_IDLE;
          end
        end
        default: begin
          done_o <= 1'b0;
          state  <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: one fast-multiply instance and
// one iterative-multiply instance share operands but have separate starts.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, hold_i, start_f, start_s;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        stall_f, done_f, stall_s, done_s;
  logic [31:0] res_f, res_s;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .FAST_MUL(1'b1)) dut_f (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .hold_i(hold_i), .start_i(start_f),
    .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .stall_req_o(stall_f), .done_o(done_f), .result_o(res_f)
  );

  muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0)) dut_s (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .hold_i(hold_i), .start_i(start_s),
    .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .stall_req_o(stall_s), .done_o(done_s), .result_o(res_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of the RV32M ops
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int          sa, sb_;
    logic        ovf;
    sa  = $signed(a);
    sb_ = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); return p[31:0]; end
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
      3'd2: begin p = longint'($signed(a)) * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb_);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb_);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_model(input bit slow, input logic [2:0] op, input logic [31:0] b, input logic [31:0] a);
    if (op[2]) begin
      if (b == 0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return slow ? 33 : 1;
  endfunction

  // Issue one op, watch it to completion, compare against the scoreboard head
  task automatic run(input bit slow, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int exp_lat, input string tag);
    exp_t        e;
    int          lat, stalls;
    bit          got;
    logic [31:0] res;
    sb.push_back('{exp, exp_lat, tag});
    op_i = op; a_i = a; b_i = b;
    if (slow) start_s = 1'b1; else start_f = 1'b1;
    lat = -1; stalls = 0; got = 1'b0; res = 'x;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (slow ? done_s : done_f) begin
        got = 1'b1;
        lat = c;
        res = slow ? res_s : res_f;
      end else begin
        if (slow ? stall_s : stall_f) stalls++;
        @(posedge clk); #1;
      end
    end
    e = sb.pop_front();
    chk({e.tag, " latency"}, 32'(lat), 32'(e.lat));
    chk({e.tag, " stall cycles"}, 32'(stalls), 32'(e.lat));
    chk({e.tag, " result"}, res, e.res);
    @(posedge clk); #1;
    start_f = 1'b0; start_s = 1'b0;
    op_i = $urandom; a_i = $urandom; b_i = $urandom;
  endtask

  initial begin
    int          dones;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    // Reset: outputs cleared, stall forced low even with start asserted
    rst_i = 1'b1; flush_i = 1'b0; hold_i = 1'b0;
    start_f = 1'b1; start_s = 1'b0; op_i = 3'd5; a_i = 32'd1; b_i = 32'd1;
    @(negedge clk);
    chk("reset stall", {31'd0, stall_f}, 32'd0);
    chk("reset done", {31'd0, done_f}, 32'd0);
    chk("reset result", res_f, 32'd0);
    @(posedge clk); #1;
    start_f = 1'b0; rst_i = 1'b0;
    @(posedge clk); #1;

    // Iterative divide and signed fixups
    run(0, 3'd5, 32'd100, 32'd7, 32'd14, 33, "DIVU 100/7");
    run(0, 3'd7, 32'd100, 32'd7, 32'd2, 33, "REMU 100/7");
    run(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "DIV -7/2");
    run(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "REM -7/2");

    // One-cycle special cases
    run(0, 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "DIVU 5/0");
    run(0, 3'd6, 32'd5, 32'd0, 32'd5, 1, "REM 5/0");
    run(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV ovf");
    run(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "REM ovf");

    // Multiplies, single-cycle and iterative
    run(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, "MULH fast");
    run(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "MULHSU fast");
    run(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, "MULHU fast");
    run(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, "MUL 7*-3 fast");
    run(1, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "MULH slow");
    run(1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "MULHSU slow");
    run(1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU slow");
    run(1, 3'd0, 32'd123456, 32'd789, model(3'd0, 32'd123456, 32'd789), 33, "MUL slow");
    run(1, 3'd1, 32'hFFFF_FFFB, 32'd3, model(3'd1, 32'hFFFF_FFFB, 32'd3), 33, "MULH -5*3 slow");

    // Mixed ops checked against the reference model
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      run(i >= 6, rop, ra, rb, model(rop, ra, rb), lat_model(i >= 6, rop, rb, ra), $sformatf("rand%0d op%0d", i, rop));
    end

    // Flush during BUSY cycle 10: no completion, result untouched
    run(0, 3'd5, 32'd77, 32'd7, 32'd11, 33, "DIVU 77/7");
    op_i = 3'd5; a_i = 32'd1000; b_i = 32'd3; start_f = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush stall", {31'd0, stall_f}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; start_f = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_f) dones++;
    end
    chk("flush no done", 32'(dones), 32'd0);
    chk("flush result kept", res_f, 32'd11);
    @(posedge clk); #1;
    run(0, 3'd5, 32'd9, 32'd3, 32'd3, 33, "DIVU 9/3 after flush");

    // hold_i keeps DONE and result stable, then back to IDLE
    op_i = 3'd3; a_i = 32'hFFFF_FFFF; b_i = 32'h0000_0010; start_f = 1'b1;
    @(posedge clk); #1;
    hold_i = 1'b1;
    @(negedge clk);
    chk("hold done c1", {31'd0, done_f}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (i == 3) hold_i = 1'b0;
      @(negedge clk);
      chk($sformatf("hold done c%0d", i + 1), {31'd0, done_f}, 32'd1);
      chk($sformatf("hold result c%0d", i + 1), res_f, 32'h0000_000F);
    end
    @(posedge clk); #1;
    start_f = 1'b0;
    @(negedge clk);
    chk("hold released done", {31'd0, done_f}, 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset mid-BUSY clears every output immediately
    op_i = 3'd5; a_i = 32'd50; b_i = 32'd5; start_f = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst busy done", {31'd0, done_f}, 32'd0);
    chk("rst busy result", res_f, 32'd0);
    chk("rst busy stall", {31'd0, stall_f}, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0; start_f = 1'b0;
    @(negedge clk);
    chk("post rst stall", {31'd0, stall_f}, 32'd0);
    @(posedge clk); #1;
    run(0, 3'd5, 32'd50, 32'd5, 32'd10, 33, "DIVU 50/5 after rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
